// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: MDU_op encodings, latencies, FSM state type.
package md_unit_pkg;

    localparam logic [4:0] MDU_NONE  = 5'd0;
    localparam logic [4:0] MDU_MULT  = 5'd1;
    localparam logic [4:0] MDU_MULTU = 5'd2;
    localparam logic [4:0] MDU_DIV   = 5'd3;
    localparam logic [4:0] MDU_DIVU  = 5'd4;
    localparam logic [4:0] MDU_MFHI  = 5'd5;
    localparam logic [4:0] MDU_MFLO  = 5'd6;
    localparam logic [4:0] MDU_MTHI  = 5'd7;
    localparam logic [4:0] MDU_MTLO  = 5'd8;
    localparam logic [4:0] MDU_MADD  = 5'd9;
    localparam logic [4:0] MDU_MADDU = 5'd10;
    localparam logic [4:0] MDU_MSUB  = 5'd11;
    localparam logic [4:0] MDU_MSUBU = 5'd12;

    // E-stage result mux select for mfhi/mflo
    localparam logic [2:0] SEL_MDU = 3'd4;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;
    localparam int unsigned CNT_W   = $clog2(DIV_LAT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Command/result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [4:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_res;

    modport master (output start, MDU_op, A, B, input busy, HI, LO, MDU_res);
    modport slave  (input start, MDU_op, A, B, output busy, HI, LO, MDU_res);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers; results commit after a fixed busy window.
// Optional build macro MDU_MADD_EN adds madd/maddu/msub/msubu.
//
// state   | meaning
// IDLE    | no op in flight; accepts start, mthi/mtlo
// RUN     | op in flight; cnt counts down, pend commits when cnt==1
module md_unit
    import md_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [63:0]      pend;

    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      div_b;
    logic [31:0]      quot_s;
    logic [31:0]      rem_s;
    logic [31:0]      quot_u;
    logic [31:0]      rem_u;
    logic [63:0]      acc;
    logic [63:0]      op_res;
    logic [CNT_W-1:0] op_lat;
    logic             op_valid;

    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u = {32'd0, bus.A} * {32'd0, bus.B};
        // Divide-by-zero keeps HI/LO, so the divisor is forced safe to avoid X
        div_b  = (bus.B == 32'd0) ? 32'd1 : bus.B;
        quot_s = $signed(bus.A) / $signed(div_b);
        rem_s  = $signed(bus.A) % $signed(div_b);
        quot_u = bus.A / div_b;
        rem_u  = bus.A % div_b;

        op_res   = acc;
        op_lat   = CNT_W'(MUL_LAT);
        op_valid = 1'b0;
        case (bus.MDU_op)
            MDU_MULT:  begin op_res = prod_s; op_valid = 1'b1; end
            MDU_MULTU: begin op_res = prod_u; op_valid = 1'b1; end
            MDU_DIV: begin
                op_res   = (bus.B == 32'd0) ? acc : {rem_s, quot_s};
                op_lat   = CNT_W'(DIV_LAT);
                op_valid = 1'b1;
            end
            MDU_DIVU: begin
                op_res   = (bus.B == 32'd0) ? acc : {rem_u, quot_u};
                op_lat   = CNT_W'(DIV_LAT);
                op_valid = 1'b1;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  begin op_res = acc + prod_s; op_valid = 1'b1; end
            MDU_MADDU: begin op_res = acc + prod_u; op_valid = 1'b1; end
            MDU_MSUB:  begin op_res = acc - prod_s; op_valid = 1'b1; end
            MDU_MSUBU: begin op_res = acc - prod_u; op_valid = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && op_valid) begin
                        pend   <= op_res;
                        cnt    <= op_lat;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else if (bus.MDU_op == MDU_MTHI) begin
                        hi_q <= bus.A;
                    end else if (bus.MDU_op == MDU_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        {hi_q, lo_q} <= pend;
                        busy_q       <= 1'b0;
                        cnt          <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.MDU_res = (bus.MDU_op == MDU_MFHI) ? hi_q :
                         (bus.MDU_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: table of mult/div vectors plus hand-written corner sequences.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md_unit_if bus();
    md_unit dut (.clk(clk), .reset(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;
    vec_t vecs[9];

    task automatic check32(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Protocol watch (pre-edge values) and commit scoreboard (post-edge values)
    logic prev_busy = 1'b0;
    int   busy_cnt  = 0;
    always @(posedge clk) begin
        exp_t e;
        if (bus.busy && (bus.start || bus.MDU_op == MDU_MTHI || bus.MDU_op == MDU_MTLO))
            viol++;
        #1;
        if (bus.busy) begin
            busy_cnt = prev_busy ? busy_cnt + 1 : 1;
        end else if (prev_busy && sb.size() > 0) begin
            e = sb.pop_front();
            check32("commit_hi", bus.HI, e.res[63:32]);
            check32("commit_lo", bus.LO, e.res[31:0]);
            check32("busy_cycles", 32'(busy_cnt), 32'(e.lat));
        end
        prev_busy = bus.busy;
    end

    task automatic launch(logic [4:0] op, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.MDU_op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.MDU_op = MDU_NONE;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d results pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic write_hilo(logic [31:0] hi, logic [31:0] lo);
        @(negedge clk); bus.MDU_op = MDU_MTHI; bus.A = hi;
        @(negedge clk); bus.MDU_op = MDU_MTLO; bus.A = lo;
        @(negedge clk); bus.MDU_op = MDU_NONE;
    endtask

    task automatic check_idle_hold(string name, logic [31:0] hi, logic [31:0] lo);
        repeat (4) begin
            @(negedge clk);
            check32({name, "_busy"}, 32'(bus.busy), 32'd0);
        end
        check32({name, "_hi"}, bus.HI, hi);
        check32({name, "_lo"}, bus.LO, lo);
    endtask

    initial begin
        bus.start = 1'b0; bus.MDU_op = MDU_NONE; bus.A = '0; bus.B = '0;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2] = '{MDU_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[3] = '{MDU_MULT,  32'h8000_0000, 32'd2,        32'hFFFF_FFFF, 32'h0000_0000, 5};
        vecs[4] = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        10};
        vecs[5] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[6] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[7] = '{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         10};
        vecs[8] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd16,       32'd15,        32'h0FFF_FFFF, 10};

        repeat (2) @(negedge clk);
        check32("reset_busy", 32'(bus.busy), 32'd0);
        check32("reset_hi", bus.HI, 32'd0);
        check32("reset_lo", bus.LO, 32'd0);
        check32("reset_res", bus.MDU_res, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            sb.push_back('{{vecs[i].hi, vecs[i].lo}, vecs[i].lat});
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_drain($sformatf("vec%0d", i));
            bus.MDU_op = MDU_MFHI; #1;
            check32($sformatf("vec%0d_mfhi", i), bus.MDU_res, vecs[i].hi);
            bus.MDU_op = MDU_MFLO; #1;
            check32($sformatf("vec%0d_mflo", i), bus.MDU_res, vecs[i].lo);
            bus.MDU_op = MDU_NONE; #1;
            check32($sformatf("vec%0d_res_none", i), bus.MDU_res, 32'd0);
        end

        // mthi/mtlo then divide by zero leaves HI/LO alone
        write_hilo(32'd1234, 32'd5678);
        check32("mthi_hi", bus.HI, 32'd1234);
        check32("mtlo_lo", bus.LO, 32'd5678);
        check32("mtx_busy", 32'(bus.busy), 32'd0);
        sb.push_back('{{32'd1234, 32'd5678}, 10});
        launch(MDU_DIV, 32'd99, 32'd0);
        wait_drain("div_by_zero");
        sb.push_back('{{32'd1234, 32'd5678}, 10});
        launch(MDU_DIVU, 32'hFFFF_FFFF, 32'd0);
        wait_drain("divu_by_zero");

        // start with non-mult/div ops is ignored
        launch(MDU_MFHI, 32'd3, 32'd4);
        check_idle_hold("start_mfhi", 32'd1234, 32'd5678);
        launch(5'd13, 32'd3, 32'd4);
        check_idle_hold("start_op13", 32'd1234, 32'd5678);

        // second start during busy: flagged, ignored, original result commits
        viol = 0;
        sb.push_back('{{32'd0, 32'd42}, 5});
        launch(MDU_MULT, 32'd6, 32'd7);
        bus.start = 1'b1; bus.MDU_op = MDU_MULT; bus.A = 32'd100; bus.B = 32'd100;
        @(negedge clk);
        bus.start = 1'b0; bus.MDU_op = MDU_NONE;
        wait_drain("restart_ignored");
        check32("restart_flagged", 32'(viol), 32'd1);

        // reset mid-run aborts the op and clears HI/LO
        launch(MDU_MULT, 32'd9, 32'd9);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check32("midrun_rst_hi", bus.HI, 32'd0);
        check32("midrun_rst_lo", bus.LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check32("post_rst_busy", 32'(bus.busy), 32'd0);
        check32("post_rst_hi", bus.HI, 32'd0);
        check32("post_rst_lo", bus.LO, 32'd0);

        write_hilo(32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        sb.push_back('{{32'd1, 32'd0}, 5});
        launch(MDU_MADDU, 32'd1, 32'd1);
        wait_drain("maddu");
        write_hilo(32'd0, 32'd0);
        sb.push_back('{{32'hFFFF_FFFF, 32'hFFFF_FFFF}, 5});
        launch(MDU_MSUB, 32'd1, 32'd1);
        wait_drain("msub");
        sb.push_back('{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, 5});
        launch(MDU_MADD, 32'hFFFF_FFFE, 32'd1);
        wait_drain("madd");
`else
        launch(MDU_MADDU, 32'd1, 32'd1);
        check_idle_hold("maddu_off", 32'd0, 32'hFFFF_FFFF);
        launch(MDU_MSUB, 32'd1, 32'd1);
        check_idle_hold("msub_off", 32'd0, 32'hFFFF_FFFF);
`endif

        check32("total_violations", 32'(viol), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
